// File: rtl/larng_pool_if.sv
// larng_pool_if: valid/ready readout port of the random-word pool.
// The pool drives the master side (head word and its valid flag);
// the LA/Wishbone glue sits on the slave side and answers with ready.
interface larng_pool_if #(
    parameter int WIDTH = 32
);
    logic             rd_vld;
    logic             rd_rdy;
    logic [WIDTH-1:0] rd_data;

    modport master (
        output rd_vld,
        output rd_data,
        input  rd_rdy
    );

    modport slave (
        input  rd_vld,
        input  rd_data,
        output rd_rdy
    );
endinterface

// File: rtl/larng_pool.sv
// larng_pool: Galois LFSR generator feeding a DEPTH-entry first-word-fall-through
// pool, drained through a valid/ready port. A seed strobe reloads the LFSR and
// flushes the pool. Defining LARNG_HEALTH_EN compiles in a repetition-count health
// test that stops generation once REP_LIMIT identical words would be produced in a
// row; without it health_err is tied low and no comparator logic exists.
module larng_pool #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = WIDTH'(32'h80200003),
    parameter int               REP_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     seed_vld,
    input  logic [WIDTH-1:0]         seed,
    larng_pool_if.master             rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     health_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    cnt;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] nxt;
    logic             full;
    logic             not_empty;
    logic             pop;
    logic             gen_ok;
    logic             trip;
    logic             push;

    // Next LFSR state and the push/pop decisions, all from registered state plus inputs.
    always_comb begin
        nxt       = (s >> 1) ^ (s[0] ? TAPS : '0);
        full      = (cnt == LW'(DEPTH));
        not_empty = (cnt != '0);
        pop       = not_empty && rd.rd_rdy && !seed_vld;
        gen_ok    = en && !seed_vld && !health_err && (!full || pop);
        push      = gen_ok && !trip;
    end

`ifdef LARNG_HEALTH_EN
    localparam int RW = $clog2(REP_LIMIT + 1);

    logic [WIDTH-1:0] last_word;
    logic [RW-1:0]    run;
    logic [RW-1:0]    run_next;
    logic             err;

    // A zero run means nothing has been generated since reset or seeding, so the
    // first word always starts a fresh run of one.
    always_comb begin
        run_next = RW'(1);
        if ((run != '0) && (nxt == last_word)) begin
            run_next = run + RW'(1);
        end
        trip = gen_ok && (run_next == RW'(REP_LIMIT));
    end

    // Track the run of identical generated words and latch a sticky failure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_word <= '0;
            run       <= '0;
            err       <= 1'b0;
        end else if (seed_vld) begin
            last_word <= '0;
            run       <= '0;
            err       <= 1'b0;
        end else if (trip) begin
            err <= 1'b1;
        end else if (push) begin
            last_word <= nxt;
            run       <= run_next;
        end
    end

    assign health_err = err;
`else
    assign trip       = 1'b0;
    assign health_err = 1'b0;
`endif

    // LFSR, pointers and occupancy; seeding restarts the generator and empties the pool.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s      <= WIDTH'(1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (seed_vld) begin
            s      <= (seed == '0) ? WIDTH'(1) : seed;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                s      <= nxt;
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + LW'(1);
            end else if (pop && !push) begin
                cnt <= cnt - LW'(1);
            end
        end
    end

    // Word storage; when full, a simultaneous pop frees the head slot the tail reuses.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= nxt;
        end
    end

    assign rd.rd_vld  = not_empty;
    assign rd.rd_data = not_empty ? mem[rd_ptr] : '0;
    assign level      = cnt;

endmodule

// File: tb/tb_larng_pool.sv
// tb_larng_pool: directed bench for larng_pool with WIDTH=8, DEPTH=8.
// dut1 uses TAPS=8'hB8 for sequence, flow-control, seeding and reset checks;
// dut2 uses TAPS=8'h01 so every generated word is 1, exercising the
// LARNG_HEALTH_EN repetition test (or its absence when the macro is undefined).
module tb_larng_pool;

    logic       clk;
    logic       rst_n;

    logic       en;
    logic       seed_vld;
    logic [7:0] seed;
    logic [3:0] level;
    logic       health_err;

    logic       en2;
    logic       seed_vld2;
    logic [7:0] seed2;
    logic [3:0] level2;
    logic       health_err2;

    int checks = 0;
    int errors = 0;

    // Hand-computed Galois sequence from state 1 with taps B8.
    logic [7:0] seq [20] = '{8'hB8, 8'h5C, 8'h2E, 8'h17, 8'hB3, 8'hE1, 8'hC8, 8'h64,
                             8'h32, 8'h19, 8'hB4, 8'h5A, 8'h2D, 8'hAE, 8'h57, 8'h93,
                             8'hF1, 8'hC0, 8'h60, 8'h30};

    larng_pool_if #(.WIDTH(8)) rd1 ();
    larng_pool_if #(.WIDTH(8)) rd2 ();

    larng_pool #(.WIDTH(8), .DEPTH(8), .TAPS(8'hB8), .REP_LIMIT(4)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seed_vld   (seed_vld),
        .seed       (seed),
        .rd         (rd1),
        .level      (level),
        .health_err (health_err)
    );

    larng_pool #(.WIDTH(8), .DEPTH(8), .TAPS(8'h01), .REP_LIMIT(4)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en2),
        .seed_vld   (seed_vld2),
        .seed       (seed2),
        .rd         (rd2),
        .level      (level2),
        .health_err (health_err2)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive dut1 inputs for exactly one rising edge; entered and left on a falling edge.
    task automatic applyStimulus(input logic e, input logic sv, input logic [7:0] sd, input logic rr);
        en        = e;
        seed_vld  = sv;
        seed      = sd;
        rd1.rd_rdy = rr;
        @(negedge clk);
    endtask

    initial begin
        rst_n      = 1'b0;
        en         = 1'b0;
        seed_vld   = 1'b0;
        seed       = 8'h00;
        rd1.rd_rdy = 1'b0;
        en2        = 1'b0;
        seed_vld2  = 1'b0;
        seed2      = 8'h00;
        rd2.rd_rdy = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_rd_vld", 32'(rd1.rd_vld), 32'h0);
        checkOutput("reset_rd_data", 32'(rd1.rd_data), 32'h0);
        checkOutput("reset_level", 32'(level), 32'h0);
        checkOutput("reset_health_err", 32'(health_err), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // Seed 1 and fill the pool with no consumer.
        applyStimulus(1'b0, 1'b1, 8'h01, 1'b0);
        checkOutput("seed_level", 32'(level), 32'h0);
        checkOutput("seed_rd_vld", 32'(rd1.rd_vld), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("first_word", 32'(rd1.rd_data), 32'hB8);
        checkOutput("first_level", 32'(level), 32'h1);
        checkOutput("first_rd_vld", 32'(rd1.rd_vld), 32'h1);
        repeat (9) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("full_level", 32'(level), 32'h8);
        checkOutput("full_head", 32'(rd1.rd_data), 32'hB8);

        // Full pool drain with refill: one word per cycle, no gap or repeat.
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("stream_word%0d", i), 32'(rd1.rd_data), 32'(seq[i]));
            checkOutput($sformatf("stream_level%0d", i), 32'(level), 32'h8);
            applyStimulus(1'b1, 1'b0, 8'h00, 1'b1);
        end
        checkOutput("stream_after_head", 32'(rd1.rd_data), 32'(seq[12]));
        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("hold_level", 32'(level), 32'h8);
        checkOutput("hold_head", 32'(rd1.rd_data), 32'(seq[12]));

        // Zero seed behaves as seed 1.
        applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
        checkOutput("zseed_level", 32'(level), 32'h0);
        checkOutput("zseed_rd_vld", 32'(rd1.rd_vld), 32'h0);
        checkOutput("zseed_rd_data", 32'(rd1.rd_data), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("zseed_first", 32'(rd1.rd_data), 32'hB8);
        repeat (4) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("zseed_level5", 32'(level), 32'h5);

        // Seed mid-stream with a concurrent pop request and enable.
        applyStimulus(1'b1, 1'b1, 8'h17, 1'b1);
        checkOutput("midseed_level", 32'(level), 32'h0);
        checkOutput("midseed_rd_vld", 32'(rd1.rd_vld), 32'h0);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("midseed_first", 32'(rd1.rd_data), 32'hB3);
        checkOutput("midseed_level1", 32'(level), 32'h1);
        repeat (2) applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("pop_head", 32'(rd1.rd_data), 32'hE1);
        checkOutput("pop_level", 32'(level), 32'h2);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("pre_reset_level", 32'(level), 32'h3);
        en = 1'b0;

        // Asynchronous reset asserted between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rd_vld", 32'(rd1.rd_vld), 32'h0);
        checkOutput("async_rd_data", 32'(rd1.rd_data), 32'h0);
        checkOutput("async_level", 32'(level), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("post_reset_first", 32'(rd1.rd_data), 32'hB8);
        checkOutput("post_reset_level", 32'(level), 32'h1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);

        // Constant-word generator on dut2.
        seed_vld2 = 1'b1;
        seed2     = 8'h01;
        @(negedge clk);
        seed_vld2 = 1'b0;
        en2       = 1'b1;
        repeat (10) @(negedge clk);
`ifdef LARNG_HEALTH_EN
        checkOutput("health_level", 32'(level2), 32'h3);
        checkOutput("health_err_set", 32'(health_err2), 32'h1);
        checkOutput("health_head", 32'(rd2.rd_data), 32'h1);
        rd2.rd_rdy = 1'b1;
        @(negedge clk);
        rd2.rd_rdy = 1'b0;
        checkOutput("health_pop_level", 32'(level2), 32'h2);
        checkOutput("health_pop_vld", 32'(rd2.rd_vld), 32'h1);
        checkOutput("health_err_sticky", 32'(health_err2), 32'h1);
        en2       = 1'b0;
        seed_vld2 = 1'b1;
        @(negedge clk);
        seed_vld2 = 1'b0;
        checkOutput("health_clear_err", 32'(health_err2), 32'h0);
        checkOutput("health_clear_level", 32'(level2), 32'h0);
        en2 = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("health_rerun_level", 32'(level2), 32'h3);
        checkOutput("health_rerun_err", 32'(health_err2), 32'h0);
        @(negedge clk);
        checkOutput("health_retrip_err", 32'(health_err2), 32'h1);
        checkOutput("health_retrip_level", 32'(level2), 32'h3);
`else
        checkOutput("nohealth_level", 32'(level2), 32'h8);
        checkOutput("nohealth_err", 32'(health_err2), 32'h0);
        checkOutput("nohealth_head", 32'(rd2.rd_data), 32'h1);
        en2       = 1'b0;
        seed_vld2 = 1'b1;
        @(negedge clk);
        seed_vld2 = 1'b0;
        checkOutput("nohealth_seed_level", 32'(level2), 32'h0);
        checkOutput("nohealth_seed_err", 32'(health_err2), 32'h0);
`endif
        en2 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/larng_pool.md
# larng_pool

Parametrised random-word pool for the laRNG user project: a Galois LFSR generator feeding a DEPTH-entry first-word-fall-through buffer. Consumers drain it through a valid/ready port driven from the logic-analyzer or Wishbone glue. Software seeding flushes the pool. An optional repetition-count health test is compiled in by macro. The block sits between the entropy/seed path and the LA/Wishbone readout registers in the user project area.

## Interface
- `WIDTH`, 32: word width in bits; ≥ 4.
- `DEPTH`, 8: pool entries; power of two, ≥ 2.
- `TAPS`, 32'h80200003: Galois feedback mask, WIDTH bits.
- `REP_LIMIT`, 4: run length of identical generated words that trips the health test; ≥ 2.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `en` in 1: generation enable.
- `seed_vld` in 1: seed load strobe, one cycle.
- `seed` in WIDTH: seed value.
- `rd_vld` out 1: pool non-empty.
- `rd_rdy` in 1: consumer accepts head word.
- `rd_data` out WIDTH: head word; 0 when `rd_vld`=0.
- `level` out $clog2(DEPTH)+1: current occupancy.
- `health_err` out 1: sticky health failure; constant 0 without the macro.

## Operation
- LFSR state `s` resets to 1.
- Step rule: `nxt = (s >> 1) ^ (s[0] ? TAPS : 0)`.
- Push condition: `en`=1, `seed_vld`=0, `health_err`=0, and either the pool is not full or a pop happens in the same cycle.
- On push: `s <= nxt`, and `nxt` is written at the tail.
- Pop condition: `rd_vld && rd_rdy`. The head advances, and `rd_data` shows the next entry in the same cycle it is exposed.
- Push and pop in the same cycle: `level` is unchanged. This is allowed when full and when `level`=1.
- Push while full with no pop: no push, and LFSR holds. No word is ever dropped or overwritten.
- Pop while empty: ignored.
- Seed load (`seed_vld`=1):
  - `s <= seed`, or 1 if `seed`=0.
  - Pool flushes: pointers and `level` go to 0.
  - Any pop that cycle is discarded.
  - `health_err` and the run counter clear.
  - No push that cycle.
- Pointers wrap modulo DEPTH. `level` ranges 0..DEPTH inclusive.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). Buffered words are lost.

## Timing
- Reset values: `rd_vld`=0, `rd_data`=0, `level`=0, `health_err`=0, LFSR=1.
- Push at edge N makes `rd_vld`=1 and the word valid on `rd_data` after edge N, so latency is 1 cycle.
- `rd_vld`, `rd_data` and `level` depend only on registered state. There is no combinational path from `rd_rdy` or `en`.
- With `en`=1 and `rd_rdy`=1 held continuously, throughput is one word per cycle after the first.
- `seed_vld` effect is visible after the same edge: `rd_vld`=0 and `level`=0.

## Configuration
- Macro: `LARNG_HEALTH_EN`.
- Defined:
  - A run counter compares each generated `nxt` against the last generated word.
  - An identical word increments the run; a different word sets it to 1.
  - When the run would reach REP_LIMIT, that word is not pushed and `health_err` is set.
  - While `health_err`=1, pushes stop, but buffered words remain readable.
  - Only seed load or reset clears it.
- Undefined: no counter or comparator logic; `health_err` is tied 0; pushes are never suppressed by health.

## Test plan
- Reset, then seed and generate (WIDTH=8, TAPS=8'hB8): seed 8'h01, then `en`=1 with `rd_rdy`=0.
  - Required: pool holds B8, 5C, 2E, 17, B3, in that order.
  - `level` reaches DEPTH, then holds, with no further LFSR steps.
- Full-pool drain and refill: fill, then `rd_rdy`=1 with `en`=1.
  - Required: `level` stays DEPTH, one word per cycle, continuing the sequence with no gap or repeat.
- Zero seed: seed 0.
  - Required: behaves exactly as seed 1; first word B8 for WIDTH=8.
- Seed mid-stream: `level`=5, then `seed_vld` with `rd_rdy`=1 in the same cycle.
  - Required: `level`=0 and `rd_vld`=0 next cycle; first subsequent word derives from the new seed.
- Async reset with `level`=3, asserted mid-cycle.
  - Required: `rd_vld`=0, `rd_data`=0, `level`=0 immediately, without waiting for a clock edge.
- Health test (`LARNG_HEALTH_EN`, TAPS=1, seed 1, REP_LIMIT=4):
  - Required: exactly 3 words of value 1 are pushed, then `health_err`=1 and pushes stop.
  - Seed 8'h01 with TAPS restored clears the error.
  - Without the macro, `health_err` stays 0 and the pool fills with 1s.
